// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences the datapath,
// latches the instruction fields and counts retired instructions.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_XOR = 3'b010,
  parameter logic [2:0] ALU_SLT = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_we,
  output logic        reg_we,
  output logic        iord,
  output logic        br_take,
  output logic [1:0]  pc_src,
  output logic        alu_srcb,
  output logic [2:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC  = 4'd3,
    S_ALUWB  = 4'd4,  S_MEMADR = 4'd5,  S_MEMRD  = 4'd6,  S_MEMWB = 4'd7,
    S_MEMWR  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JAL   = 4'd11,
    S_JR     = 4'd12, S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t     cur, nxt;
  logic [5:0] op_q, fn_q;

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) dispatch = S_EXEC;
        else if (fn == FN_JR)                             dispatch = S_JR;
        else                                              dispatch = S_HALT;
      end
      OP_ADDI, OP_XORI: dispatch = S_EXEC;
      OP_LW, OP_SW:     dispatch = S_MEMADR;
      OP_BEQ, OP_BNE:   dispatch = S_BRANCH;
      OP_J:             dispatch = S_JUMP;
      OP_JAL:           dispatch = S_JAL;
      default:          dispatch = S_HALT;
    endcase
  endfunction

  function automatic logic [2:0] exec_alu_op(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) begin
      if (fn == FN_SUB)      exec_alu_op = ALU_SUB;
      else if (fn == FN_SLT) exec_alu_op = ALU_SLT;
      else                   exec_alu_op = ALU_ADD;
    end else if (op == OP_XORI) begin
      exec_alu_op = ALU_XOR;
    end else begin
      exec_alu_op = ALU_ADD;
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_RST;
    else       cur <= nxt;
  end

  // Instruction fields are captured with the IR so later states ignore the live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      fn_q <= '0;
    end else if (ir_we) begin
      op_q <= opcode;
      fn_q <= funct;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               instr_count <= '0;
    else if (nxt == S_FETCH && cur != S_RST) instr_count <= instr_count + 32'd1;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = dispatch(op_q, fn_q);
      S_EXEC:   nxt = S_ALUWB;
      S_MEMADR: nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    br_take    = 1'b0;
    pc_src     = 2'd0;
    alu_srcb   = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    halted     = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_EXEC: begin
        alu_op   = exec_alu_op(op_q, fn_q);
        alu_srcb = (op_q != OP_RTYPE);
      end
      S_ALUWB: begin
        alu_op   = exec_alu_op(op_q, fn_q);
        alu_srcb = (op_q != OP_RTYPE);
        reg_we   = 1'b1;
        reg_dst  = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
      end
      S_MEMADR: alu_srcb = 1'b1;
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      // The only Mealy output: branch decision follows the live zero flag.
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        pc_we   = 1'b1;
        br_take = (op_q == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd1;
      end
      S_JAL: begin
        pc_we      = 1'b1;
        pc_src     = 2'd1;
        reg_we     = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
      end
      S_JR: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model queues the expected
// per-cycle outputs; a negedge process compares the DUT against that queue.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        pc_we, ir_we, mem_we, reg_we, iord, br_take, alu_srcb, halted;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we), .iord(iord),
    .br_take(br_take), .pc_src(pc_src), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_we, ir_we, mem_we, reg_we, iord, br_take;
    logic [1:0]  pc_src;
    logic        alu_srcb;
    logic [2:0]  alu_op;
    logic [1:0]  reg_dst, mem_to_reg;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t        act;
  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_pulses = 0;
  logic [31:0] mcount = '0;

  assign act = {state, pc_we, ir_we, mem_we, reg_we, iord, br_take, pc_src,
                alu_srcb, alu_op, reg_dst, mem_to_reg, halted, instr_count};

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  function automatic exp_t base(input logic [3:0] st);
    exp_t r;
    r        = '0;
    r.st     = st;
    r.alu_op = 3'b000;
    r.cnt    = mcount;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) wr_pulses++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("cycle_state%0d", e.st), act, e);
    end
  end

  // Called one step after the edge that entered FETCH; queues the whole instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int exp_cpi, input string nm);
    exp_t r;
    int   n;
    logic trap;
    trap   = 1'b0;
    opcode = op;
    funct  = fn;
    zero   = z;
    r = base(4'd1); r.ir_we = 1'b1; r.pc_we = 1'b1; q.push_back(r);
    r = base(4'd2); q.push_back(r);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      r = base(4'd3);
      r.alu_op = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
      q.push_back(r);
      r.st = 4'd4; r.reg_we = 1'b1; r.reg_dst = 2'd1; q.push_back(r);
    end else if (op == 6'h08 || op == 6'h0E) begin
      r = base(4'd3); r.alu_srcb = 1'b1;
      r.alu_op = (op == 6'h0E) ? 3'b010 : 3'b000;
      q.push_back(r);
      r.st = 4'd4; r.reg_we = 1'b1; q.push_back(r);
    end else if (op == 6'h23) begin
      r = base(4'd5); r.alu_srcb = 1'b1; q.push_back(r);
      r = base(4'd6); r.iord = 1'b1; q.push_back(r);
      r = base(4'd7); r.reg_we = 1'b1; r.mem_to_reg = 2'd1; q.push_back(r);
    end else if (op == 6'h2B) begin
      r = base(4'd5); r.alu_srcb = 1'b1; q.push_back(r);
      r = base(4'd8); r.iord = 1'b1; r.mem_we = 1'b1; q.push_back(r);
    end else if (op == 6'h04 || op == 6'h05) begin
      r = base(4'd9); r.alu_op = 3'b001; r.pc_we = 1'b1;
      r.br_take = (op == 6'h04) ? z : ~z;
      q.push_back(r);
    end else if (op == 6'h02) begin
      r = base(4'd10); r.pc_we = 1'b1; r.pc_src = 2'd1; q.push_back(r);
    end else if (op == 6'h03) begin
      r = base(4'd11); r.pc_we = 1'b1; r.pc_src = 2'd1; r.reg_we = 1'b1;
      r.reg_dst = 2'd2; r.mem_to_reg = 2'd2; q.push_back(r);
    end else if (op == 6'h00 && fn == 6'h08) begin
      r = base(4'd12); r.pc_we = 1'b1; r.pc_src = 2'd2; q.push_back(r);
    end else begin
      trap = 1'b1;
      for (int i = 0; i < 20; i++) begin
        r = base(4'd15); r.halted = 1'b1; q.push_back(r);
      end
    end
    n = q.size();
    @(posedge clk); #1;
    opcode = ~op;
    funct  = ~fn;
    repeat (n - 1) @(posedge clk);
    #1;
    if (!trap) begin
      mcount = mcount + 32'd1;
      check({nm, "_cpi"}, n, exp_cpi);
      check({nm, "_refetch"}, state, 4'd1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = '0;
    funct  = '0;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 4'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_count", instr_count, 32'd0);
    check("rst_enables", {pc_we, ir_we, mem_we, reg_we}, 4'b0000);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("first_fetch", state, 4'd1);

    run_instr(6'h00, 6'h20, 1'b0, 4, "add");
    check("add_count", instr_count, 32'd1);
    run_instr(6'h23, 6'h00, 1'b0, 5, "lw");
    wr_pulses = 0;
    run_instr(6'h2B, 6'h00, 1'b0, 4, "sw");
    check("sw_we_pulses", wr_pulses, 1);
    check("lwsw_count", instr_count, 32'd3);
    run_instr(6'h00, 6'h22, 1'b0, 4, "sub");
    run_instr(6'h00, 6'h2A, 1'b1, 4, "slt");
    run_instr(6'h08, 6'h15, 1'b0, 4, "addi");
    run_instr(6'h0E, 6'h3F, 1'b0, 4, "xori");
    run_instr(6'h04, 6'h00, 1'b1, 3, "beq_z1");
    run_instr(6'h05, 6'h00, 1'b1, 3, "bne_z1");
    run_instr(6'h04, 6'h00, 1'b0, 3, "beq_z0");
    run_instr(6'h05, 6'h00, 1'b0, 3, "bne_z0");
    run_instr(6'h02, 6'h00, 1'b0, 3, "j");
    run_instr(6'h03, 6'h00, 1'b0, 3, "jal");
    run_instr(6'h00, 6'h08, 1'b0, 3, "jr");
    check("mix_count", instr_count, 32'd14);

    run_instr(6'h3F, 6'h00, 1'b0, 0, "illegal");
    check("halt_flag", halted, 1'b1);
    check("halt_count", instr_count, 32'd14);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", state, 4'd0);
    check("async_rst_halted", halted, 1'b0);
    check("async_rst_count", instr_count, 32'd0);

    force dut.instr_count = 32'hFFFF_FFFF;
    @(negedge clk) reset = 1'b0;
    mcount = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.instr_count;
    check("preload", instr_count, 32'hFFFF_FFFF);
    run_instr(6'h00, 6'h20, 1'b0, 4, "wrap_add");
    check("wrap_count", instr_count, 32'd0);

    // Abort a store while its address is being formed.
    opcode = 6'h2B;
    funct  = 6'h00;
    begin
      exp_t r;
      r = base(4'd1); r.ir_we = 1'b1; r.pc_we = 1'b1; q.push_back(r);
      r = base(4'd2); q.push_back(r);
      r = base(4'd5); r.alu_srcb = 1'b1; q.push_back(r);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    wr_pulses = 0;
    reset = 1'b1;
    #1;
    check("abort_state", state, 4'd0);
    check("abort_writes", {mem_we, reg_we}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("abort_no_pulse", wr_pulses, 0);
    check("abort_count", instr_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
